// File: rtl/breath_pkg.sv
// Shared encodings for the LED breathing generator.
// Mode and ramp-direction types used by the channel and top.
package breath_pkg;

  typedef enum logic [1:0] {
    MODE_TRIANGLE = 2'b00,
    MODE_SAW      = 2'b01,
    MODE_FADE_IN  = 2'b10,
    MODE_FADE_OUT = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/breath_pwm_gen_channel.sv
// One breathing channel: duty ramp per mode plus registered PWM.
// Duty only moves on the shared tick; idle channels park at rest.
module breath_channel
  import breath_pkg::*;
#(
  parameter int DUTY_MAX = 10,
  parameter int DUTY_W   = $clog2(DUTY_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              active,
  input  logic              tick,
  input  mode_e             mode,
  input  logic [DUTY_W-1:0] pwm_cnt,
  output logic [DUTY_W-1:0] duty,
  output logic              pwm,
  output logic              done
);

  localparam logic [DUTY_W-1:0] MAX_V = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] ONE   = DUTY_W'(1);

  logic [DUTY_W-1:0] duty_q, duty_d;
  dir_e              dir_q, dir_d;
  logic              done_q, done_d;
  logic              pwm_q, pwm_d;
  logic              at_max, at_min, hold;
  logic              up;

  assign at_max = (duty_q == MAX_V);
  assign at_min = (duty_q == '0);
  assign up     = (dir_q == DIR_UP);

  // Single-shot modes sitting on their end value.
  assign hold = ((mode == MODE_FADE_IN) && at_max) ||
                ((mode == MODE_FADE_OUT) && at_min);

  always_comb begin
    duty_d = duty_q;
    dir_d  = dir_q;
    done_d = hold && (done_q || tick);
    pwm_d  = (pwm_cnt < duty_q);
    if (!active) begin
      duty_d = (mode == MODE_FADE_OUT) ? MAX_V : '0;
      dir_d  = DIR_UP;
      done_d = 1'b0;
      pwm_d  = 1'b0;
    end else if (tick) begin
      unique case (mode)
        MODE_TRIANGLE: begin
          unique case (1'b1)
            up && !at_max:  duty_d = duty_q + ONE;
            up && at_max: begin
              dir_d  = DIR_DOWN;
              duty_d = MAX_V - ONE;
            end
            !up && !at_min: duty_d = duty_q - ONE;
            !up && at_min: begin
              dir_d  = DIR_UP;
              duty_d = ONE;
            end
          endcase
        end
        MODE_SAW:
          duty_d = at_max ? '0 : duty_q + ONE;
        MODE_FADE_IN:
          if (!at_max) duty_d = duty_q + ONE;
        MODE_FADE_OUT:
          if (!at_min) duty_d = duty_q - ONE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_q <= '0;
      dir_q  <= DIR_UP;
      done_q <= 1'b0;
      pwm_q  <= 1'b0;
    end else begin
      duty_q <= duty_d;
      dir_q  <= dir_d;
      done_q <= done_d;
      pwm_q  <= pwm_d;
    end
  end

  assign duty = duty_q;
  assign pwm  = pwm_q;
  assign done = done_q;

endmodule

// File: rtl/breath_pwm_gen.sv
// Multi-channel LED breathing generator with per-channel PWM.
// Owns the shared step timer, PWM counter and step tick.
module breath_pwm_gen
  import breath_pkg::*;
#(
  parameter  int CHANNELS    = 4,
  parameter  int DUTY_MAX    = 10,
  parameter  int STEP_CYCLES = 20,
  localparam int DUTY_W      = $clog2(DUTY_MAX + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [CHANNELS-1:0]        ch_en,
  input  logic [2*CHANNELS-1:0]      mode,
  output logic [DUTY_W*CHANNELS-1:0] duty,
  output logic [CHANNELS-1:0]        pwm,
  output logic [CHANNELS-1:0]        done
);

  localparam int STEP_W = $clog2(STEP_CYCLES);
  localparam logic [STEP_W-1:0] STEP_LAST =
    STEP_W'(STEP_CYCLES - 1);
  localparam logic [DUTY_W-1:0] PWM_LAST =
    DUTY_W'(DUTY_MAX - 1);

  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic [DUTY_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic              tick;

  assign tick = en && (step_cnt_q == STEP_LAST);

  always_comb begin
    step_cnt_d = '0;
    pwm_cnt_d  = '0;
    if (en) begin
      step_cnt_d = tick ? '0 : step_cnt_q + STEP_W'(1);
      pwm_cnt_d  = (pwm_cnt_q == PWM_LAST) ?
                   '0 : pwm_cnt_q + DUTY_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_cnt_q <= '0;
      pwm_cnt_q  <= '0;
    end else begin
      step_cnt_q <= step_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    breath_channel #(
      .DUTY_MAX (DUTY_MAX),
      .DUTY_W   (DUTY_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .active  (en && ch_en[i]),
      .tick    (tick),
      .mode    (mode_e'(mode[2*i +: 2])),
      .pwm_cnt (pwm_cnt_q),
      .duty    (duty[DUTY_W*i +: DUTY_W]),
      .pwm     (pwm[i]),
      .done    (done[i])
    );
  end

endmodule

// File: tb/tb_breath_pwm_gen.sv
// Bench for breath_pwm_gen: directed scenarios plus random
// stimulus against an arithmetic reference model.
module tb_breath_pwm_gen;

  localparam int CH = 2;
  localparam int DM = 3;
  localparam int SC = 4;
  localparam int DW = $clog2(DM + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [CH-1:0]   ch_en;
  logic [2*CH-1:0] mode;
  logic [DW*CH-1:0] duty;
  logic [CH-1:0]   pwm;
  logic [CH-1:0]   done;

  logic        en2;
  logic [3:0]  ch_en2;
  logic [7:0]  mode2;
  logic [15:0] duty2;
  logic [3:0]  pwm2;
  logic [3:0]  done2;

  int checks = 0;
  int failures = 0;

  int m_duty[CH];
  bit m_down[CH];
  bit m_done[CH];
  bit m_pwm[CH];
  int m_step;
  int m_pcnt;

  always #5 clk = ~clk;

  breath_pwm_gen #(
    .CHANNELS(CH), .DUTY_MAX(DM), .STEP_CYCLES(SC)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .ch_en(ch_en),
    .mode(mode), .duty(duty), .pwm(pwm), .done(done)
  );

  breath_pwm_gen dut_def (
    .clk(clk), .rst(rst), .en(en2), .ch_en(ch_en2),
    .mode(mode2), .duty(duty2), .pwm(pwm2), .done(done2)
  );

  always @(negedge clk) begin
    for (int i = 0; i < CH; i++)
      assert (int'(duty[DW*i +: DW]) <= DM)
        else $error("duty out of range ch%0d", i);
    for (int i = 0; i < 4; i++)
      assert (int'(duty2[4*i +: 4]) <= 10)
        else $error("default duty out of range ch%0d", i);
  end

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_duty[i] = 0;
      m_down[i] = 0;
      m_done[i] = 0;
      m_pwm[i]  = 0;
    end
    m_step = 0;
    m_pcnt = 0;
  endtask

  // Expected state after the coming clock edge.
  task automatic model_step();
    bit tk, act, at_end;
    int d, md;
    tk = en && (m_step == SC - 1);
    for (int i = 0; i < CH; i++) begin
      act = en && ch_en[i];
      md  = int'((mode >> (2 * i)) & 4'd3);
      d   = m_duty[i];
      m_pwm[i] = act && (m_pcnt < d);
      at_end = (md == 2 && d == DM) || (md == 3 && d == 0);
      if (!act) begin
        m_duty[i] = (md == 3) ? DM : 0;
        m_down[i] = 0;
        m_done[i] = 0;
      end else begin
        m_done[i] = at_end && (m_done[i] || tk);
        if (tk) begin
          case (md)
            0: begin
              d = m_down[i] ? d - 1 : d + 1;
              if (d > DM) begin
                d = DM - 1;
                m_down[i] = 1;
              end else if (d < 0) begin
                d = 1;
                m_down[i] = 0;
              end
            end
            1: d = (d + 1) % (DM + 1);
            2: d = (d < DM) ? d + 1 : d;
            default: d = (d > 0) ? d - 1 : 0;
          endcase
        end
        m_duty[i] = d;
      end
    end
    m_step = en ? (m_step + 1) % SC : 0;
    m_pcnt = en ? (m_pcnt + 1) % DM : 0;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    en = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 0; ch_en = '0; mode = '0;
    en2 = 0; ch_en2 = '0; mode2 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (duty !== '0 || pwm !== '0 || done !== '0) begin
      failures++;
      $display("FAIL reset_outs: got duty=%h pwm=%b done=%b expected 0",
               duty, pwm, done);
    end
    checks++;
    if (duty2 !== '0 || pwm2 !== '0 || done2 !== '0) begin
      failures++;
      $display("FAIL reset_def: got duty=%h pwm=%b done=%b expected 0",
               duty2, pwm2, done2);
    end
    rst = 1'b0;
    cycle();
    checks++;
    if (duty !== '0) begin
      failures++;
      $display("FAIL reset_release: got duty=%h expected 0", duty);
    end
  endtask

  task automatic test_triangle();
    int seq[7] = '{1, 2, 3, 2, 1, 0, 1};
    ch_en = 2'b01; mode = 4'b0000; en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      cycle();
      checks++;
      if (duty[1:0] !== 2'd0) begin
        failures++;
        $display("FAIL tri_first_wait: edge %0d got %0d expected 0",
                 k, duty[1:0]);
      end
    end
    foreach (seq[s]) begin
      repeat (4) begin
        cycle();
        checks++;
        if (int'(duty[1:0]) != seq[s] || duty[3:2] !== 2'd0 ||
            pwm[1] !== 1'b0) begin
          failures++;
          $display("FAIL tri_seq: step %0d got d0=%0d d1=%0d p1=%b expected d0=%0d d1=0 p1=0",
                   s, duty[1:0], duty[3:2], pwm[1], seq[s]);
        end
      end
    end
    idle(1);
  endtask

  task automatic test_saw_pwm();
    int ed, ep;
    ch_en = 2'b01; mode = 4'b0001; en = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cycle();
      ed = (k / SC) % (DM + 1);
      ep = (((k - 1) % DM) < (((k - 1) / SC) % (DM + 1))) ? 1 : 0;
      checks++;
      if (int'(duty[1:0]) != ed || int'(pwm[0]) != ep) begin
        failures++;
        $display("FAIL saw_pwm: edge %0d got d=%0d p=%b expected d=%0d p=%0d",
                 k, duty[1:0], pwm[0], ed, ep);
      end
    end
    idle(1);
  endtask

  task automatic test_single_shot();
    int t, e0, e1;
    logic [1:0] edn;
    ch_en = 2'b11; mode = 4'b1110;
    idle(1);
    en = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cycle();
      t = k / SC;
      e0 = (t < DM) ? t : DM;
      e1 = (DM - t > 0) ? DM - t : 0;
      edn = (k >= 4 * SC) ? 2'b11 : 2'b00;
      checks++;
      if (int'(duty[1:0]) != e0 || int'(duty[3:2]) != e1 ||
          done !== edn) begin
        failures++;
        $display("FAIL single_shot: edge %0d got d0=%0d d1=%0d done=%b expected %0d %0d %b",
                 k, duty[1:0], duty[3:2], done, e0, e1, edn);
      end
    end
    ch_en = 2'b00;
    cycle();
    checks++;
    if (duty !== {2'd3, 2'd0} || done !== 2'b00) begin
      failures++;
      $display("FAIL single_shot_off: got duty=%h done=%b expected c 00",
               duty, done);
    end
    idle(1);
  endtask

  task automatic test_mode_switch();
    int ed;
    ch_en = 2'b01; mode = 4'b0000; en = 1'b1;
    repeat (8) cycle();
    checks++;
    if (duty[1:0] !== 2'd2) begin
      failures++;
      $display("FAIL switch_pre: got %0d expected 2", duty[1:0]);
    end
    mode = 4'b0011;
    for (int k = 9; k <= 20; k++) begin
      cycle();
      ed = (k < 12) ? 2 : (k < 16) ? 1 : 0;
      checks++;
      if (int'(duty[1:0]) != ed || done[0] !== (k >= 20)) begin
        failures++;
        $display("FAIL switch_fade: edge %0d got d=%0d done=%b expected d=%0d done=%0d",
                 k, duty[1:0], done[0], ed, k >= 20);
      end
    end
    mode = 4'b0000;
    for (int k = 21; k <= 32; k++) begin
      cycle();
      ed = (k < 24) ? 0 : (k < 28) ? 1 : (k < 32) ? 2 : 3;
      checks++;
      if (int'(duty[1:0]) != ed || done[0] !== 1'b0) begin
        failures++;
        $display("FAIL switch_back: edge %0d got d=%0d done=%b expected d=%0d done=0",
                 k, duty[1:0], done[0], ed);
      end
    end
    idle(1);
  endtask

  task automatic test_disable_reset();
    ch_en = 2'b11; mode = 4'b1100;
    idle(1);
    en = 1'b1;
    repeat (6) cycle();
    checks++;
    if (duty !== {2'd2, 2'd1}) begin
      failures++;
      $display("FAIL dis_pre: got duty=%h expected 9", duty);
    end
    en = 1'b0;
    cycle();
    checks++;
    if (duty !== {2'd3, 2'd0} || pwm !== '0 || done !== '0) begin
      failures++;
      $display("FAIL dis_clear: got duty=%h pwm=%b done=%b expected c 00 00",
               duty, pwm, done);
    end
    en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cycle();
      checks++;
      if (int'(duty[1:0]) != ((k < 4) ? 0 : 1) ||
          int'(duty[3:2]) != ((k < 4) ? 3 : 2)) begin
        failures++;
        $display("FAIL reenable: edge %0d got duty=%h", k, duty);
      end
    end
    cycle();
    #3 rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (duty !== '0 || pwm !== '0 || done !== '0) begin
      failures++;
      $display("FAIL async_rst: got duty=%h pwm=%b done=%b expected 0",
               duty, pwm, done);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cycle();
      checks++;
      if (int'(duty[1:0]) != ((k < 4) ? 0 : 1)) begin
        failures++;
        $display("FAIL post_rst: edge %0d got %0d expected %0d",
                 k, duty[1:0], (k < 4) ? 0 : 1);
      end
    end
    idle(1);
  endtask

  task automatic test_random();
    logic [DW*CH-1:0] ed;
    logic [CH-1:0] ep, edn;
    en = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 39) == 0) en = ~en;
      if ($urandom_range(0, 9) == 0) ch_en = CH'($urandom);
      if ($urandom_range(0, 14) == 0) mode = (2*CH)'($urandom);
      cycle();
      for (int i = 0; i < CH; i++) begin
        ed[DW*i +: DW] = DW'(m_duty[i]);
        ep[i]  = m_pwm[i];
        edn[i] = m_done[i];
      end
      checks++;
      if (duty !== ed || pwm !== ep || done !== edn) begin
        failures++;
        $display("FAIL random: cyc %0d got duty=%h pwm=%b done=%b expected %h %b %b",
                 n, duty, pwm, done, ed, ep, edn);
      end
    end
    idle(1);
  endtask

  task automatic test_defaults();
    int d, peak, first10;
    peak = 0;
    first10 = 0;
    ch_en2 = 4'b0001; mode2 = '0; en2 = 1'b1;
    for (int k = 1; k <= 420; k++) begin
      cycle();
      d = int'(duty2[3:0]);
      if (d > peak) peak = d;
      if (d == 10 && first10 == 0) first10 = k;
      if (k == 400) begin
        checks++;
        if (d != 0) begin
          failures++;
          $display("FAIL def_trough: got %0d expected 0", d);
        end
      end
      if (k == 420) begin
        checks++;
        if (d != 1) begin
          failures++;
          $display("FAIL def_period: got %0d expected 1", d);
        end
      end
    end
    checks++;
    if (first10 != 200 || peak != 10) begin
      failures++;
      $display("FAIL def_peak: got edge=%0d peak=%0d expected 200 10",
               first10, peak);
    end
    en2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_triangle();
    test_saw_pwm();
    test_single_shot();
    test_mode_switch();
    test_disable_reset();
    test_random();
    test_defaults();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
